// File: rtl/zmc_alu_mc.sv
// zmc_alu_mc: handshaked ALU for the ZMC datapath.
// Single-cycle ops register their result at the accepting edge. MUL/DIV run
// iteratively, one bit per clock, in a shared 2*DATA_WL accumulator.
//
// Handshake: an input transfer happens on a rising clk edge where
// valid_in && ready_out. ready_out is a registered signal: it is low during
// reset, low while an iterative op is in BUSY, and high otherwise. There is no
// output backpressure. valid_out is a one-cycle pulse, and c_out and the flags
// hold their values until the next result.
//
// The FSM state is kept in state_q (type state_t) so it can be probed directly.
module zmc_alu_mc #(
    parameter int DATA_WL = 16,
    parameter int OP_WL   = 8
) (
    input  logic               clk,
    input  logic               a_reset,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [DATA_WL-1:0] a_in,
    input  logic [DATA_WL-1:0] b_in,
    input  logic [OP_WL-1:0]   op_in,
    input  logic               c_flag_in,
    input  logic               ovr_flag_in,
    output logic [DATA_WL-1:0] c_out,
    output logic               z_flag_out,
    output logic               s_flag_out,
    output logic               c_flag_out,
    output logic               ovr_flag_out,
    output logic               valid_out
);

    localparam int W  = DATA_WL;
    localparam int CW = $clog2(W + 1);

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_ADC   = 5'h01;
    localparam logic [4:0] OP_SUB   = 5'h02;
    localparam logic [4:0] OP_SBC   = 5'h03;
    localparam logic [4:0] OP_AND   = 5'h04;
    localparam logic [4:0] OP_OR    = 5'h05;
    localparam logic [4:0] OP_XOR   = 5'h06;
    localparam logic [4:0] OP_NOT   = 5'h07;
    localparam logic [4:0] OP_SHL   = 5'h08;
    localparam logic [4:0] OP_SHR   = 5'h09;
    localparam logic [4:0] OP_ASR   = 5'h0A;
    localparam logic [4:0] OP_PASS  = 5'h0B;
    localparam logic [4:0] OP_MULLO = 5'h10;
    localparam logic [4:0] OP_MULHI = 5'h11;
    localparam logic [4:0] OP_DIVU  = 5'h12;
    localparam logic [4:0] OP_REMU  = 5'h13;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    opnd_q, opnd_d;   // multiplicand or divisor
    logic [1:0]      mop_q, mop_d;     // 0 MULLO, 1 MULHI, 2 DIVU, 3 REMU
    logic [W-1:0]    res_q, res_d;
    logic            z_q, z_d, s_q, s_d, cf_q, cf_d, of_q, of_d;
    logic            valid_q, valid_d;
    logic            ready_q;

    logic [4:0]      op5;
    logic            accept;
    logic            is_multi;
    logic            use_cin;
    logic [W:0]      add_sum, sub_diff;
    logic [W-1:0]    sc_res;
    logic            sc_c, sc_o;
    logic [2*W-1:0]  iter_acc;
    logic [W:0]      mul_add, rem_sh, rem_trial;
    logic [W-1:0]    fin_res;
    logic            fin_c;

    // Only the low five opcode bits are decoded.
    generate
        if (OP_WL > 5) begin : g_op_hi
            logic unused_op_hi;
            assign unused_op_hi = ^op_in[OP_WL-1:5];
        end
    endgenerate

    assign op5       = op_in[4:0];
    assign accept    = valid_in && ready_q;
    assign ready_out = ready_q;
    assign c_out        = res_q;
    assign z_flag_out   = z_q;
    assign s_flag_out   = s_q;
    assign c_flag_out   = cf_q;
    assign ovr_flag_out = of_q;
    assign valid_out    = valid_q;

    // Single-cycle result, flags and multi-cycle classification from live inputs.
    always_comb begin
        use_cin  = (op5 == OP_ADC) || (op5 == OP_SBC);
        add_sum  = {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, use_cin & c_flag_in};
        sub_diff = {1'b0, a_in} - {1'b0, b_in} - {{W{1'b0}}, use_cin & c_flag_in};
        sc_res   = a_in;
        sc_c     = c_flag_in;
        sc_o     = ovr_flag_in;
        is_multi = 1'b0;
        case (op5)
            OP_ADD, OP_ADC: begin
                sc_res = add_sum[W-1:0];
                sc_c   = add_sum[W];
                sc_o   = (a_in[W-1] == b_in[W-1]) && (add_sum[W-1] != a_in[W-1]);
            end
            OP_SUB, OP_SBC: begin
                sc_res = sub_diff[W-1:0];
                sc_c   = sub_diff[W];
                sc_o   = (a_in[W-1] != b_in[W-1]) && (sub_diff[W-1] != a_in[W-1]);
            end
            OP_AND:  sc_res = a_in & b_in;
            OP_OR:   sc_res = a_in | b_in;
            OP_XOR:  sc_res = a_in ^ b_in;
            OP_NOT:  sc_res = ~a_in;
            OP_PASS: sc_res = b_in;
            OP_SHL: begin
                sc_res = {a_in[W-2:0], 1'b0};
                sc_c   = a_in[W-1];
            end
            OP_SHR: begin
                sc_res = {1'b0, a_in[W-1:1]};
                sc_c   = a_in[0];
            end
            OP_ASR: begin
                sc_res = {a_in[W-1], a_in[W-1:1]};
                sc_c   = a_in[0];
            end
            OP_MULLO, OP_MULHI: is_multi = 1'b1;
            OP_DIVU, OP_REMU: begin
                // Divide by zero resolves immediately without iterating.
                if (b_in != '0) begin
                    is_multi = 1'b1;
                end else begin
                    sc_res = (op5 == OP_DIVU) ? {W{1'b1}} : a_in;
                    sc_c   = 1'b1;
                    sc_o   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // One multiply (add-then-shift) or restoring-divide step on the accumulator.
    always_comb begin
        mul_add   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        rem_sh    = acc_q[2*W-1:W-1];
        rem_trial = rem_sh - {1'b0, opnd_q};
        if (!mop_q[1]) begin
            iter_acc = {mul_add, acc_q[W-1:1]};
        end else if (rem_sh >= {1'b0, opnd_q}) begin
            iter_acc = {rem_trial[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            iter_acc = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
        end
        fin_c = 1'b0;
        case (mop_q)
            2'd0: begin
                fin_res = iter_acc[W-1:0];
                fin_c   = (iter_acc[2*W-1:W] != '0);
            end
            2'd1:    fin_res = iter_acc[2*W-1:W];
            2'd2:    fin_res = iter_acc[W-1:0];
            default: fin_res = iter_acc[2*W-1:W];
        endcase
    end

    // Next-state, datapath and result-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        mop_d   = mop_q;
        res_d   = res_q;
        cf_d    = cf_q;
        of_d    = of_q;
        valid_d = 1'b0;
        case (state_q)
            ST_BUSY: begin
                acc_d = iter_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == '0) begin
                    state_d = ST_DONE;
                    res_d   = fin_res;
                    cf_d    = fin_c;
                    of_d    = fin_c;
                    valid_d = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new transfer.
                state_d = ST_IDLE;
                if (accept) begin
                    if (is_multi) begin
                        state_d = ST_BUSY;
                        cnt_d   = CW'(W);
                        mop_d   = op5[1:0];
                        acc_d   = op5[1] ? {{W{1'b0}}, a_in} : {{W{1'b0}}, b_in};
                        opnd_d  = op5[1] ? b_in : a_in;
                    end else begin
                        res_d   = sc_res;
                        cf_d    = sc_c;
                        of_d    = sc_o;
                        valid_d = 1'b1;
                    end
                end
            end
        endcase
        z_d = z_q;
        s_d = s_q;
        if (valid_d) begin
            z_d = (res_d == '0);
            s_d = res_d[W-1];
        end
    end

    // State, datapath and output registers; reset aborts any in-flight op.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            mop_q   <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            s_q     <= 1'b0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            mop_q   <= mop_d;
            res_q   <= res_d;
            z_q     <= z_d;
            s_q     <= s_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            valid_q <= valid_d;
            ready_q <= (state_d != ST_BUSY);
        end
    end

endmodule

// File: tb/tb_zmc_alu_mc.sv
// Directed bench for zmc_alu_mc (DATA_WL=16, OP_WL=8).
module tb_zmc_alu_mc;

  logic        clk;
  logic        a_reset;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [7:0]  op_in;
  logic        c_flag_in;
  logic        ovr_flag_in;
  logic [15:0] c_out;
  logic        z_flag_out;
  logic        s_flag_out;
  logic        c_flag_out;
  logic        ovr_flag_out;
  logic        valid_out;

  int total = 0;
  int bad   = 0;

  // scoreboard entries: {result, z, s, c, ovr}
  logic [19:0] exp_q[$];

  wire [3:0] flags = {z_flag_out, s_flag_out, c_flag_out, ovr_flag_out};

  zmc_alu_mc #(.DATA_WL(16), .OP_WL(8)) dut (
    .clk          (clk),
    .a_reset      (a_reset),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .a_in         (a_in),
    .b_in         (b_in),
    .op_in        (op_in),
    .c_flag_in    (c_flag_in),
    .ovr_flag_in  (ovr_flag_in),
    .c_out        (c_out),
    .z_flag_out   (z_flag_out),
    .s_flag_out   (s_flag_out),
    .c_flag_out   (c_flag_out),
    .ovr_flag_out (ovr_flag_out),
    .valid_out    (valid_out)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ci, input logic oi);
    valid_in    = v;
    op_in       = op;
    a_in        = a;
    b_in        = b;
    c_flag_in   = ci;
    ovr_flag_in = oi;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // single-cycle op: result and valid_out one cycle after transfer
  task automatic do_single(input string tag, input logic [7:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic ci, input logic oi,
                           input logic [15:0] er, input logic [3:0] ef);
    drive(1'b1, op, a, b, ci, oi);
    step();
    valid_in = 1'b0;
    check({tag, "_valid"}, valid_out, 1);
    check({tag, "_res"}, c_out, er);
    check({tag, "_flags"}, flags, ef);
    step();
    check({tag, "_vdrop"}, valid_out, 0);
  endtask

  // iterative op: measure latency and ready_out low time; optionally poke
  // valid_in during BUSY, which must be ignored
  task automatic do_multi(input string tag, input logic [7:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] er,
                          input logic [3:0] ef, input bit pulse);
    int lat;
    int rdy_low;
    int extra;
    drive(1'b1, op, a, b, 1'b0, 1'b0);
    step();
    valid_in = 1'b0;
    lat = 1;
    rdy_low = 0;
    while (valid_out !== 1'b1 && lat < 40) begin
      if (ready_out === 1'b0) rdy_low++;
      if (pulse && lat == 5) drive(1'b1, 8'h00, 16'h0001, 16'h0001, 1'b0, 1'b0);
      else valid_in = 1'b0;
      step();
      lat++;
    end
    valid_in = 1'b0;
    check({tag, "_latency"}, lat, 17);
    check({tag, "_ready_low"}, rdy_low, 16);
    check({tag, "_res"}, c_out, er);
    check({tag, "_flags"}, flags, ef);
    check({tag, "_ready_done"}, ready_out, 1);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (valid_out === 1'b1) extra++;
    end
    check({tag, "_no_extra_valid"}, extra, 0);
    check({tag, "_hold"}, c_out, er);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] ra, rb;
    logic [16:0] sum;
    logic [15:0] res;
    logic [3:0]  ef;
    logic [19:0] e;
    logic [7:0]  b2b_op [4];
    logic [19:0] b2b_exp[4];
    int pulses;

    a_reset = 1'b0;
    drive(1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #2 a_reset = 1'b1;
    step();
    step();
    check("rst_c_out", c_out, 0);
    check("rst_flags", flags, 0);
    check("rst_valid", valid_out, 0);
    check("rst_ready", ready_out, 0);
    a_reset = 1'b0;
    #1;
    check("ready_before_edge", ready_out, 0);
    step();
    check("ready_after_edge", ready_out, 1);

    // arithmetic
    do_single("add_ovf", 8'h00, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b0101);
    do_single("sub_borrow", 8'h02, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'hFFFE, 4'b0110);
    do_single("adc_wrap", 8'h01, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b1010);
    do_single("sbc_cin", 8'h03, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 4'b0110);
    do_single("add_hi_op_bits", 8'hE0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 4'b0000);

    // shifts, pass and undefined opcode
    do_single("shr", 8'h09, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'h0001, 4'b0011);
    do_single("asr", 8'h0A, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'hC000, 4'b0110);
    do_single("not", 8'h07, 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'hFF00, 4'b0101);
    do_single("pass_b", 8'h0B, 16'h1234, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'b1001);
    do_single("undef_op", 8'h0C, 16'h8000, 16'h5555, 1'b1, 1'b1, 16'h8000, 4'b0111);

    // small random ADD sweep against a reference sum
    for (int i = 0; i < 4; i++) begin
      ra  = 16'($urandom_range(0, 16'hFFFF));
      rb  = 16'($urandom_range(0, 16'hFFFF));
      sum = {1'b0, ra} + {1'b0, rb};
      res = sum[15:0];
      ef  = {res == 16'h0000, res[15], sum[16], (ra[15] == rb[15]) && (res[15] != ra[15])};
      do_single($sformatf("rand_add%0d", i), 8'h00, ra, rb, 1'b0, 1'b0, res, ef);
    end

    // iterative multiply / divide
    do_multi("mullo", 8'h10, 16'h0100, 16'h0100, 16'h0000, 4'b1011, 1'b1);
    do_multi("mulhi", 8'h11, 16'h0100, 16'h0100, 16'h0001, 4'b0000, 1'b0);
    do_multi("mullo_b", 8'h10, 16'h1234, 16'h0003, 16'h369C, 4'b0000, 1'b0);
    do_multi("divu", 8'h12, 16'h0064, 16'h0007, 16'h000E, 4'b0000, 1'b0);
    do_multi("remu", 8'h13, 16'h0064, 16'h0007, 16'h0002, 4'b0000, 1'b1);
    do_single("divu_by0", 8'h12, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 4'b0110);
    do_single("remu_by0", 8'h13, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h1234, 4'b0010);

    // four back-to-back single-cycle ops
    b2b_op[0] = 8'h06; b2b_exp[0] = {16'hFF00, 4'b0110};
    b2b_op[1] = 8'h04; b2b_exp[1] = {16'h00F0, 4'b0010};
    b2b_op[2] = 8'h05; b2b_exp[2] = {16'hFFF0, 4'b0110};
    b2b_op[3] = 8'h08; b2b_exp[3] = {16'hE1E0, 4'b0110};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, b2b_op[i], 16'hF0F0, 16'h0FF0, 1'b1, 1'b0);
      exp_q.push_back(b2b_exp[i]);
      step();
      check($sformatf("b2b%0d_valid", i), valid_out, 1);
      check($sformatf("b2b%0d_ready", i), ready_out, 1);
      e = exp_q.pop_front();
      check($sformatf("b2b%0d_out", i), {c_out, flags}, e);
    end
    valid_in = 1'b0;
    step();
    check("b2b_vdrop", valid_out, 0);

    // reset during BUSY iteration 5 of a MULLO
    drive(1'b1, 8'h10, 16'h0100, 16'h0100, 1'b0, 1'b0);
    step();
    valid_in = 1'b0;
    repeat (4) step();
    check("midrst_busy_ready", ready_out, 0);
    a_reset = 1'b1;
    #1;
    check("midrst_c_out", c_out, 0);
    check("midrst_flags", flags, 0);
    check("midrst_valid", valid_out, 0);
    check("midrst_ready", ready_out, 0);
    step();
    step();
    a_reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid_out === 1'b1) pulses++;
    end
    check("midrst_no_valid", pulses, 0);
    check("midrst_ready_back", ready_out, 1);
    do_single("add_after_rst", 8'h00, 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 4'b0000);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
